// File: rtl/fpga_io_pkg.sv
// rtl/fpga_io_pkg.sv - shared types for the board I/O conditioning logic
package fpga_io_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PWAIT = 3'd1,
        S_DOWN  = 3'd2,
        S_HELD  = 3'd3,
        S_RWAIT = 3'd4
    } debounce_state_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: 2-FF synchroniser, debounce FSM, press/release/hold
module debounce_channel
    import fpga_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 100_000_000,
    parameter int CNT_W           = 28
) (
    input  logic clk,
    input  logic clear_n,
    input  logic raw,
    output logic level,
    output logic press_evt,
    output logic release_evt,
    output logic hold
);

    localparam logic [CNT_W-1:0] DEB_LOAD  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic            sync_meta;
    logic            sync;
    debounce_state_t state;
    logic [CNT_W-1:0] cnt;
    logic            held;

    assign hold = held;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync_meta   <= 1'b0;
            sync        <= 1'b0;
            state       <= S_IDLE;
            cnt         <= '0;
            level       <= 1'b0;
            held        <= 1'b0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
        end else begin
            sync_meta   <= raw;
            sync        <= sync_meta;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sync) begin
                        state <= S_PWAIT;
                        cnt   <= DEB_LOAD;
                    end
                end
                S_PWAIT: begin
                    if (!sync) begin
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        state     <= S_DOWN;
                        level     <= 1'b1;
                        press_evt <= 1'b1;
                        cnt       <= HOLD_LOAD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_DOWN: begin
                    if (!sync) begin
                        state <= S_RWAIT;
                        cnt   <= DEB_LOAD;
                    end else if (cnt == '0) begin
                        state <= S_HELD;
                        held  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_HELD: begin
                    if (!sync) begin
                        state <= S_RWAIT;
                        cnt   <= DEB_LOAD;
                    end
                end
                S_RWAIT: begin
                    // A release glitch that recovers restarts the hold timer unless already held.
                    if (sync) begin
                        if (held) begin
                            state <= S_HELD;
                        end else begin
                            state <= S_DOWN;
                            cnt   <= HOLD_LOAD;
                        end
                    end else if (cnt == '0) begin
                        state       <= S_IDLE;
                        level       <= 1'b0;
                        held        <= 1'b0;
                        release_evt <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    level <= 1'b0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - array of independent debounced pushbutton channels
module button_debouncer
    import fpga_io_pkg::*;
#(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 100_000_000,
    parameter int CNT_W           = 28
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_hold
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk        (clk),
            .clear_n    (clear_n),
            .raw        (btn_raw[i]),
            .level      (btn_level[i]),
            .press_evt  (btn_press[i]),
            .release_evt(btn_release[i]),
            .hold       (btn_hold[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed and random checks of button_debouncer against a run-length model
module tb_button_debouncer;

    localparam int NB = 2;
    localparam int D  = 4;
    localparam int H  = 10;

    logic          clk = 1'b0;
    logic          clear_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_hold;

    button_debouncer #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .CNT_W(4)
    ) dut (
        .clk(clk), .clear_n(clear_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_hold(btn_hold)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int t0       = 0;
    logic saw_press, saw_release;

    // Reference: a change is accepted after D+1 consecutive agreeing synchronised samples;
    // hold needs H consecutive high samples after the press (or after a recovered glitch).
    logic [NB-1:0] m_level, m_held, m_press, m_rel, d1, d2;
    int orun [NB];
    int zrun [NB];
    int hrun [NB];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level = '0; m_held = '0; m_press = '0; m_rel = '0; d1 = '0; d2 = '0;
        for (int c = 0; c < NB; c++) begin
            orun[c] = 0; zrun[c] = 0; hrun[c] = 0;
        end
    endtask

    task automatic model_step();
        logic s;
        for (int c = 0; c < NB; c++) begin
            s = d2[c];
            d2[c] = d1[c];
            d1[c] = btn_raw[c];
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            if (!m_level[c]) begin
                orun[c] = s ? orun[c] + 1 : 0;
                if (orun[c] == D + 1) begin
                    m_level[c] = 1'b1; m_press[c] = 1'b1;
                    orun[c] = 0; hrun[c] = 0; zrun[c] = 0;
                end
            end else if (!s) begin
                zrun[c]++;
                if (zrun[c] == D + 1) begin
                    m_level[c] = 1'b0; m_held[c] = 1'b0; m_rel[c] = 1'b1; zrun[c] = 0;
                end
            end else if (zrun[c] > 0) begin
                zrun[c] = 0;
                hrun[c] = 0;
            end else if (!m_held[c]) begin
                hrun[c]++;
                if (hrun[c] == H) m_held[c] = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        check("level",   32'(btn_level),   32'(m_level));
        check("press",   32'(btn_press),   32'(m_press));
        check("release", 32'(btn_release), 32'(m_rel));
        check("hold",    32'(btn_hold),    32'(m_held));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!clear_n) model_reset(); else model_step();
        edge_cnt++;
        @(negedge clk);
        if (btn_press != '0)   saw_press = 1'b1;
        if (btn_release != '0) saw_release = 1'b1;
        compare_model();
    endtask

    task automatic wait_bit(input int sig, input int ch, output int rel_edge);
        logic v;
        rel_edge = -1;
        for (int i = 0; i < 64; i++) begin
            tick();
            case (sig)
                0:       v = btn_level[ch];
                1:       v = btn_press[ch];
                2:       v = btn_release[ch];
                default: v = btn_hold[ch];
            endcase
            if (v) begin
                rel_edge = edge_cnt - t0;
                return;
            end
        end
    endtask

    int e;

    initial begin
        model_reset();
        saw_press = 1'b0;
        saw_release = 1'b0;

        // 1: reset with toggling input, then release with input low
        for (int i = 0; i < 6; i++) begin
            btn_raw = ~btn_raw;
            tick();
            check("reset_outputs", 32'({btn_level, btn_press, btn_release, btn_hold}), 32'd0);
        end
        btn_raw = '0;
        clear_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("post_reset_outputs", 32'({btn_level, btn_press, btn_release, btn_hold}), 32'd0);

        // 2 + 4: press latency, single-cycle press, hold latency, release latency
        btn_raw[0] = 1'b1; t0 = edge_cnt;
        wait_bit(0, 0, e);
        check("press_edge", 32'(e), 32'(D + 3));
        check("press_pulse", 32'(btn_press), 32'b01);
        tick();
        check("press_one_cycle", 32'(btn_press[0]), 32'd0);
        check("chan1_untouched", 32'({btn_level[1], btn_press[1]}), 32'd0);
        wait_bit(3, 0, e);
        check("hold_edge", 32'(e), 32'(D + H + 3));
        while (edge_cnt - t0 < 20) tick();
        btn_raw[0] = 1'b0; t0 = edge_cnt;
        wait_bit(2, 0, e);
        check("release_edge", 32'(e), 32'(D + 3));
        check("release_level_hold", 32'({btn_level[0], btn_hold[0]}), 32'd0);

        // 3: short bounce never accepted
        for (int i = 0; i < 5; i++) tick();
        saw_press = 1'b0;
        btn_raw[0] = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        btn_raw[0] = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("bounce_no_press", 32'({saw_press, btn_level[0]}), 32'd0);

        // 5: release glitch in S_DOWN restarts hold timer without releasing
        btn_raw[0] = 1'b1; t0 = edge_cnt;
        wait_bit(0, 0, e);
        saw_release = 1'b0;
        btn_raw[0] = 1'b0;
        tick();
        tick();
        btn_raw[0] = 1'b1; t0 = edge_cnt;
        wait_bit(3, 0, e);
        check("glitch_hold_edge", 32'(e), 32'(3 + H));
        check("glitch_no_release", 32'(saw_release), 32'd0);
        btn_raw[0] = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // 6: simultaneous press, then reset mid debounce
        btn_raw = 2'b11; t0 = edge_cnt;
        wait_bit(0, 0, e);
        check("dual_press_edge", 32'(e), 32'(D + 3));
        check("dual_press_vec", 32'(btn_press), 32'b11);
        btn_raw = '0;
        for (int i = 0; i < 10; i++) tick();
        btn_raw = 2'b11;
        for (int i = 0; i < 4; i++) tick();
        saw_press = 1'b0;
        clear_n = 1'b0;
        btn_raw = '0;
        model_reset();
        #1;
        check("async_clear", 32'({btn_level, btn_press, btn_release, btn_hold}), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) tick();
        clear_n = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("clear_no_press", 32'(saw_press), 32'd0);

        // random bouncing on both channels
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                int b;
                b = int'($urandom_range(0, NB - 1));
                btn_raw[b] = ~btn_raw[b];
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
